// File: rtl/eq_pair_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eq_seq_pkg
// Purpose : Shared state encoding and default constants for the sequencer.
// Revision: 1.0
// ============================================================================
package eq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         DEF_W    = 4;
    localparam logic [3:0] DEF_SEED = 4'b0001;
    localparam logic [3:0] DEF_TAPS = 4'b1100;
    localparam logic [7:0] ERR_MAX  = 8'd255;

endpackage
`default_nettype wire

// File: rtl/eq_pair_sequencer_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_gen
// Purpose : Fibonacci-style LFSR; value_o is the value to use this cycle.
// Revision: 1.0
// ============================================================================
module lfsr_gen #(
    parameter int           W    = 4,
    parameter logic [W-1:0] SEED = W'(1),
    parameter logic [W-1:0] TAPS = W'(12)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // A load presents SEED immediately so the caller can consume it and step in one edge.
    assign value_o = load_i ? SEED : lfsr_q;
    assign lfsr_d  = {value_o[W-2:0], ^(value_o & TAPS)};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (load_i || step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eq_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : eq_pair_sequencer
// Purpose : Issues equal/one-bit-different operand pairs and checks `equal`.
// Revision: 1.0
// ============================================================================
module eq_pair_sequencer
    import eq_seq_pkg::*;
#(
    parameter int           W         = DEF_W,
    parameter int           NUM_PAIRS = 16,
    parameter logic [W-1:0] SEED      = W'(DEF_SEED),
    parameter logic [W-1:0] TAPS      = W'(DEF_TAPS),
    parameter int           SETTLE    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         equal,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [7:0]   err_count,
    output logic [7:0]   pairs_done
);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         exp_q, exp_d;
    logic         done_q, done_d;
    logic [7:0]   err_q, err_d;
    logic [7:0]   pairs_q, pairs_d;
    logic [2:0]   settle_q, settle_d;

    logic         w_go;
    logic         w_sample;
    logic         w_more;
    logic [W-1:0] w_lfsr;
    logic [7:0]   w_idx;
    logic [W-1:0] w_flip;
    logic [W-1:0] w_b_next;

    assign w_go     = start && (state_q != CHECK);
    assign w_sample = (state_q == CHECK) && (settle_q == 3'(SETTLE));
    assign w_more   = ({1'b0, pairs_q} + 9'd1) < 9'(NUM_PAIRS);

    // Index of the pair about to be loaded: 0 on start, otherwise the one after the pair in flight.
    assign w_idx    = (state_q == CHECK) ? pairs_q + 8'd1 : 8'd0;
    assign w_flip   = W'(1) << (32'(w_idx) % 32'(W));
    assign w_b_next = w_idx[0] ? (w_lfsr ^ w_flip) : w_lfsr;

    lfsr_gen #(
        .W    (W),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_go),
        .step_i  (w_sample && w_more),
        .value_o (w_lfsr)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        exp_d    = exp_q;
        err_d    = err_q;
        pairs_d  = pairs_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (w_go) begin
                    a_d      = w_lfsr;
                    b_d      = w_b_next;
                    exp_d    = ~w_idx[0];
                    err_d    = 8'd0;
                    pairs_d  = 8'd0;
                    settle_d = 3'd0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (w_sample) begin
                    if ((equal != exp_q) && (err_q != ERR_MAX)) begin
                        err_d = err_q + 8'd1;
                    end
                    pairs_d = pairs_q + 8'd1;
                    if (w_more) begin
                        a_d      = w_lfsr;
                        b_d      = w_b_next;
                        exp_d    = ~w_idx[0];
                        settle_d = 3'd0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            exp_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 8'd0;
            pairs_q  <= 8'd0;
            settle_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            exp_q    <= exp_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pairs_q  <= pairs_d;
            settle_q <= settle_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign busy       = (state_q == CHECK);
    assign done       = done_q;
    assign err_count  = err_q;
    assign pairs_done = pairs_q;

endmodule
`default_nettype wire

// File: tb/tb_eq_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_eq_pair_sequencer
// Purpose : Directed bench for eq_pair_sequencer with a modelled comparator.
// Revision: 1.0
// ============================================================================
module tb_eq_pair_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] mode = 2'd0;   // 0 correct, 1 stuck-at-1, 2 inverted

    logic [3:0] a0, b0, a2, b2;
    logic       eq0, eq2_q;
    logic       busy0, done0, busy2, done2;
    logic [7:0] err0, pairs0, err2, pairs2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int seen_done;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            2'd1:    eq0 = 1'b1;
            2'd2:    eq0 = (a0 != b0);
            default: eq0 = (a0 == b0);
        endcase
    end

    always @(posedge clk) eq2_q <= (a2 == b2);

    eq_pair_sequencer #(.W(4), .NUM_PAIRS(16), .SEED(4'b0001), .TAPS(4'b1100), .SETTLE(0)) dut (
        .clk(clk), .rst(rst), .start(start0), .equal(eq0),
        .A(a0), .B(b0), .busy(busy0), .done(done0),
        .err_count(err0), .pairs_done(pairs0)
    );

    eq_pair_sequencer #(.W(4), .NUM_PAIRS(16), .SEED(4'b0001), .TAPS(4'b1100), .SETTLE(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start2), .equal(eq2_q),
        .A(a2), .B(b2), .busy(busy2), .done(done2),
        .err_count(err2), .pairs_done(pairs2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run0();
        start0 = 1'b1;
        cyc = 0;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done0();
        while (!done0 && cyc < 200) tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_A", 32'(a0), 32'h0);
        check("rst_B", 32'(b0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_done", 32'(done0), 32'h0);
        check("rst_err", 32'(err0), 32'h0);
        check("rst_pairs", 32'(pairs0), 32'h0);

        // Correct comparator: first pairs and run length
        mode = 2'd0;
        start_run0();
        check("p0_A", 32'(a0), 32'h1);
        check("p0_B", 32'(b0), 32'h1);
        check("p0_busy", 32'(busy0), 32'h1);
        tick();
        check("p1_A", 32'(a0), 32'h2);
        check("p1_B", 32'(b0), 32'h0);
        tick();
        check("p2_A", 32'(a0), 32'h4);
        check("p2_B", 32'(b0), 32'h4);
        tick();
        check("p3_A", 32'(a0), 32'h9);
        check("p3_B", 32'(b0), 32'h1);
        wait_done0();
        check("ok_done_cyc", 32'(cyc), 32'd17);
        check("ok_err", 32'(err0), 32'd0);
        check("ok_pairs", 32'(pairs0), 32'd16);
        check("ok_busy_at_done", 32'(busy0), 32'h0);
        tick();
        check("ok_done_pulse", 32'(done0), 32'h0);
        check("ok_pairs_hold", 32'(pairs0), 32'd16);

        // Stuck-at-1 comparator
        mode = 2'd1;
        start_run0();
        wait_done0();
        check("stuck_done_cyc", 32'(cyc), 32'd17);
        check("stuck_err", 32'(err0), 32'd8);

        // Inverted comparator
        mode = 2'd2;
        start_run0();
        wait_done0();
        check("inv_err", 32'(err0), 32'd16);
        check("inv_pairs", 32'(pairs0), 32'd16);

        // Start while busy is ignored
        mode = 2'd0;
        start_run0();
        while (cyc < 4) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("restart_busy", 32'(busy0), 32'h1);
        wait_done0();
        check("restart_done_cyc", 32'(cyc), 32'd17);
        check("restart_err", 32'(err0), 32'd0);
        check("restart_pairs", 32'(pairs0), 32'd16);

        // Reset mid-run (stuck comparator so counters are nonzero first)
        mode = 2'd1;
        start_run0();
        while (cyc < 6) tick();
        check("pre_rst_err", 32'(err0), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy0), 32'h0);
        check("mid_rst_A", 32'(a0), 32'h0);
        check("mid_rst_B", 32'(b0), 32'h0);
        check("mid_rst_err", 32'(err0), 32'd0);
        check("mid_rst_pairs", 32'(pairs0), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done0) seen_done = 1;
            tick();
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);
        mode = 2'd0;
        start_run0();
        check("rerun_p0_A", 32'(a0), 32'h1);
        check("rerun_p0_B", 32'(b0), 32'h1);
        wait_done0();

        // SETTLE=2 with registered comparator
        start2 = 1'b1;
        cyc = 0;
        tick();
        start2 = 1'b0;
        check("s2_p0_A", 32'(a2), 32'h1);
        tick(); tick();
        check("s2_hold_A", 32'(a2), 32'h1);
        tick();
        check("s2_p1_A", 32'(a2), 32'h2);
        check("s2_p1_B", 32'(b2), 32'h0);
        while (!done2 && cyc < 200) tick();
        check("s2_done_cyc", 32'(cyc), 32'd49);
        check("s2_err", 32'(err2), 32'd0);
        check("s2_pairs", 32'(pairs2), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
